// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, the instruction word layout
// and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_ZERO   = 4'h4;
    localparam logic [3:0] OP_ONE    = 4'h5;
    localparam logic [3:0] OP_XOR    = 4'h6;
    localparam logic [3:0] OP_STATUS = 4'hF;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] data;
    } instr_t;

    localparam instr_t NOP_INSTR = '{opcode: OP_NOP, data: 8'h00};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/alu_seq_buf.sv
// Program storage for the ALU sequencer: DEPTH x 12-bit instruction words,
// one synchronous write port and one asynchronous read port driven by the
// program counter.
module alu_seq_buf
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  instr_t        wr_instr_i,
    input  logic [AW-1:0] rd_addr_i,
    output instr_t        rd_instr_o
);

    instr_t mem_q [DEPTH];

    // Store the offered instruction; contents survive reset so a program can be re-run.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_instr_i;
        end
    end

    assign rd_instr_o = mem_q[rd_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: buffers a short program from the host and replays it to a
// downstream ALU at one instruction per cycle, then captures the final result.
// Optional feature macro: ALU_SEQ_REPEAT_EN adds rep_count, replaying the
// program rep_count+1 times back-to-back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [3:0]    wr_opcode,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    input  logic          start,
`ifdef ALU_SEQ_REPEAT_EN
    input  logic [3:0]    rep_count,
`endif
    output logic [3:0]    alu_opcode,
    output logic [7:0]    alu_data,
    input  logic [7:0]    alu_result,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result,
    output logic [CW-1:0] count
);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pc_q, pc_d;
    instr_t        alu_q;
    logic [7:0]    result_q;
    instr_t        rdInstr;

    logic startOk;
    logic issue;
    logic lastEntry;
    logic wrap;
    logic wrEn;

`ifdef ALU_SEQ_REPEAT_EN
    logic [3:0] repLeft_q, repLeft_d;
    logic [3:0] repNow;
`endif

    assign startOk   = (state_q == ST_IDLE) && start && (count_q != '0);
    assign issue     = startOk || ((state_q == ST_RUN) && (pc_q != count_q));
    assign lastEntry = (pc_q == (count_q - CW'(1)));
    assign wrEn      = wr_valid && wr_ready && !clear;

`ifdef ALU_SEQ_REPEAT_EN
    assign repNow = startOk ? rep_count : repLeft_q;
    assign wrap   = lastEntry && (repNow != 4'd0);
`else
    assign wrap   = 1'b0;
`endif

    alu_seq_buf #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .wr_en_i    (wrEn),
        .wr_addr_i  (count_q[AW-1:0]),
        .wr_instr_i ('{opcode: wr_opcode, data: wr_data}),
        .rd_addr_i  (pc_q[AW-1:0]),
        .rd_instr_o (rdInstr)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (startOk) state_d = ST_RUN;
            ST_RUN:   if (pc_q == count_q) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: status flags and write handshake.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        wr_ready = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
    end

    // Program counter advance; the counter parks at count once the last pass is issued.
    always_comb begin
        pc_d = pc_q;
`ifdef ALU_SEQ_REPEAT_EN
        repLeft_d = repLeft_q;
`endif
        if (issue) begin
            if (!lastEntry) begin
                pc_d = pc_q + CW'(1);
            end else if (wrap) begin
                pc_d = '0;
            end else begin
                pc_d = count_q;
            end
`ifdef ALU_SEQ_REPEAT_EN
            repLeft_d = wrap ? (repNow - 4'd1) : repNow;
`endif
        end else if (state_q != ST_RUN) begin
            pc_d = '0;
        end
    end

    // Buffer occupancy: clear wins over a write, both only honoured in IDLE.
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_IDLE) && clear) begin
            count_d = '0;
        end else if (wrEn) begin
            count_d = count_q + CW'(1);
        end
    end

    // Datapath registers: issued instruction (nop when idle) and captured result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            pc_q     <= '0;
            alu_q    <= NOP_INSTR;
            result_q <= 8'h00;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            alu_q   <= issue ? rdInstr : NOP_INSTR;
            if (state_q == ST_DRAIN) begin
                result_q <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_REPEAT_EN
    // Remaining repetitions of the program, loaded at start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repLeft_q <= 4'd0;
        end else begin
            repLeft_q <= repLeft_d;
        end
    end
`endif

    assign alu_opcode = alu_q.opcode;
    assign alu_data   = alu_q.data;
    assign result     = result_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU, an issue
// scoreboard and a result scoreboard. Honours ALU_SEQ_REPEAT_EN.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_opcode;
    logic [7:0]    wr_data;
    logic          clear;
    logic          start;
    logic [3:0]    rep_count;
    logic [3:0]    alu_opcode;
    logic [7:0]    alu_data;
    logic [7:0]    alu_result;
    logic          busy;
    logic          done;
    logic [7:0]    result;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    instr_t     prog[$];
    instr_t     issueQ[$];
    logic [7:0] resultQ[$];

    logic [7:0] acc;
    logic       zeroF, negF, borF;
    logic [8:0] aluR;
    logic       aluUpd;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_opcode  (wr_opcode),
        .wr_data    (wr_data),
        .clear      (clear),
        .start      (start),
`ifdef ALU_SEQ_REPEAT_EN
        .rep_count  (rep_count),
`endif
        .alu_opcode (alu_opcode),
        .alu_data   (alu_data),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [3:0] op, input logic [7:0] d,
                                 input logic clr, input logic st);
        wr_valid  = wv;
        wr_opcode = op;
        wr_data   = d;
        clear     = clr;
        start     = st;
    endtask

    task automatic loadInstr(input logic [3:0] op, input logic [7:0] d);
        applyStimulus(1'b1, op, d, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        prog.push_back('{opcode: op, data: d});
    endtask

    task automatic clearProg();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        prog.delete();
    endtask

    task automatic startRun(input logic [7:0] expResult, input int reps);
        for (int r = 0; r < reps; r++) begin
            foreach (prog[k]) issueQ.push_back(prog[k]);
        end
        resultQ.push_back(expResult);
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 1'b0);
    endtask

    // Behavioural downstream ALU: registered data_out, status byte {borrow, negative, zero}.
    always @(posedge clk) begin
        aluR   = {1'b0, acc};
        aluUpd = 1'b1;
        case (alu_opcode)
            OP_LOAD: aluR = {1'b0, alu_data};
            OP_ADD:  aluR = {1'b0, acc} + {1'b0, alu_data};
            OP_SUB:  aluR = {1'b0, acc} - {1'b0, alu_data};
            OP_ZERO: aluR = 9'h000;
            OP_ONE:  aluR = 9'h001;
            OP_XOR:  aluR = {1'b0, acc ^ alu_data};
            default: aluUpd = 1'b0;
        endcase
        if (aluUpd) begin
            acc        <= aluR[7:0];
            alu_result <= aluR[7:0];
            zeroF      <= (aluR[7:0] == 8'h00);
            negF       <= aluR[7];
            borF       <= (alu_opcode == OP_SUB) && aluR[8];
        end else if (alu_opcode == OP_STATUS) begin
            alu_result <= {5'b00000, borF, negF, zeroF};
        end
    end

    // Scoreboard monitor: every issued instruction and every done pulse is matched to an expectation.
    always @(negedge clk) begin
        if (alu_opcode != OP_NOP) begin
            if (issueQ.size() == 0) begin
                checkOutput("issue_unexpected", {alu_opcode, alu_data}, 32'h0);
            end else begin
                checkOutput("issue", {alu_opcode, alu_data}, issueQ.pop_front());
            end
        end
        if (done) begin
            if (resultQ.size() == 0) begin
                checkOutput("done_unexpected", done, 1'b0);
            end else begin
                checkOutput("result", result, resultQ.pop_front());
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequence.
    initial begin
        int reps;
        acc        = 8'h00;
        alu_result = 8'h00;
        zeroF      = 1'b0;
        negF       = 1'b0;
        borF       = 1'b0;
        rep_count  = 4'd0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);

        // Reset state
        step();
        step();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_opcode", alu_opcode, 4'h0);
        checkOutput("rst_data", alu_data, 8'h00);
        checkOutput("rst_result", result, 8'h00);
        rst_n = 1'b1;
        step();
        checkOutput("rst_wr_ready", wr_ready, 1'b1);

        // Two-entry program: LOAD 5, ADD 3 -> 8, cycle-accurate timing
        loadInstr(OP_LOAD, 8'h05);
        loadInstr(OP_ADD, 8'h03);
        checkOutput("load2_count", count, 2);
        startRun(8'h08, 1);
        checkOutput("c1_busy", busy, 1'b1);
        checkOutput("c1_opcode", alu_opcode, OP_LOAD);
        step();
        checkOutput("c2_opcode", alu_opcode, OP_ADD);
        checkOutput("c2_data", alu_data, 8'h03);
        step();
        checkOutput("c3_nop", alu_opcode, OP_NOP);
        checkOutput("c3_done", done, 1'b0);
        checkOutput("c3_busy", busy, 1'b1);
        step();
        checkOutput("c4_done", done, 1'b1);
        checkOutput("c4_result", result, 8'h08);
        step();
        checkOutput("c5_busy", busy, 1'b0);
        checkOutput("c5_done", done, 1'b0);
        checkOutput("c5_count_kept", count, 2);
        checkOutput("c5_result_hold", result, 8'h08);

        // Re-run preserved program
        startRun(8'h08, 1);
        waitIdle(20);

        // Clear beats a same-cycle write
        applyStimulus(1'b1, OP_LOAD, 8'hAA, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        prog.delete();
        checkOutput("clear_prio_count", count, 0);

        // Status program: LOAD 5, SUB 6, STATUS -> 0x06, busy cycles 1..5
        loadInstr(OP_LOAD, 8'h05);
        loadInstr(OP_SUB, 8'h06);
        loadInstr(OP_STATUS, 8'h00);
        startRun(8'h06, 1);
        for (int c = 1; c <= 5; c++) begin
            checkOutput($sformatf("status_busy_c%0d", c), busy, 1'b1);
            step();
        end
        checkOutput("status_busy_c6", busy, 1'b0);
        checkOutput("status_result", result, 8'h06);

        // Start ignored when empty, and start/clear ignored while busy
        clearProg();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        checkOutput("empty_start_busy", busy, 1'b0);
        step();
        checkOutput("empty_start_done", done, 1'b0);
        loadInstr(OP_ONE, 8'h00);
        startRun(8'h01, 1);
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        waitIdle(20);
        checkOutput("busy_clear_ignored", count, 1);
        for (int i = 0; i < 4; i++) step();

        // Fill to DEPTH with wr_valid held; the extra entry must be refused
        clearProg();
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == 0) applyStimulus(1'b1, OP_LOAD, 8'h10, 1'b0, 1'b0);
            else if (i == DEPTH) applyStimulus(1'b1, OP_ADD, 8'h40, 1'b0, 1'b0);
            else applyStimulus(1'b1, OP_ADD, 8'h01, 1'b0, 1'b0);
            checkOutput($sformatf("fill_ready_%0d", i), wr_ready, (i < DEPTH));
            if (i < DEPTH) prog.push_back('{opcode: wr_opcode, data: wr_data});
            step();
        end
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_ready", wr_ready, 1'b0);
        checkOutput("full_count", count, DEPTH);
        startRun(8'(8'h10 + DEPTH - 1), 1);
        waitIdle(40);

        // Repeat program (once when the repeat feature is absent), no gaps between passes
        clearProg();
        loadInstr(OP_LOAD, 8'h01);
        loadInstr(OP_ADD, 8'h01);
`ifdef ALU_SEQ_REPEAT_EN
        reps = 3;
        rep_count = 4'd2;
`else
        reps = 1;
`endif
        startRun(8'h02, reps);
        rep_count = 4'd0;
        for (int k = 0; k < 2 * reps; k++) begin
            checkOutput($sformatf("rep_issue_%0d", k), alu_opcode, prog[k % 2].opcode);
            step();
        end
        checkOutput("rep_drain_nop", alu_opcode, OP_NOP);
        waitIdle(20);

        // Reset mid-run aborts without a done pulse
        clearProg();
        loadInstr(OP_LOAD, 8'h01);
        loadInstr(OP_ADD, 8'h01);
        loadInstr(OP_ADD, 8'h01);
        loadInstr(OP_ADD, 8'h01);
        issueQ.push_back(prog[0]);
        issueQ.push_back(prog[1]);
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("abort_c2_opcode", alu_opcode, OP_ADD);
        rst_n = 1'b0;
        step();
        checkOutput("abort_opcode", alu_opcode, OP_NOP);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_count", count, 0);
        rst_n = 1'b1;
        prog.delete();
        for (int i = 0; i < 6; i++) step();
        checkOutput("abort_wr_ready", wr_ready, 1'b1);

        checkOutput("issueQ_empty", issueQ.size(), 0);
        checkOutput("resultQ_empty", resultQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
